// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types, defaults and checksum helper for the
// UART frame transmitter (uart_frame_tx, uart_byte_tx).
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [15:0] LIDAR_HEADER         = 16'h55AA;
    localparam int          DEFAULT_CLKS_PER_BIT = 868;
    localparam int          MAX_PAYLOAD_BYTES    = 16;
    localparam int          MAX_PAYLOAD_W        = MAX_PAYLOAD_BYTES * 8;

    // Modulo-256 sum of all bytes; callers zero-extend narrower payloads,
    // so unused upper bytes contribute nothing.
    function automatic logic [7:0] payload_checksum(
        input logic [MAX_PAYLOAD_W-1:0] data
    );
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            sum = sum + data[i*8 +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one 8N1 byte (start, 8 data LSB first, stop).
// Ports: clk, reset (async, active-low), byte_valid/byte_data (load
// request, sampled in IDLE or on the last stop-bit cycle so consecutive
// bytes run without gaps), byte_done (pulse on last stop-bit cycle), txd.
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       txd
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          baud_last;
    logic          load;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        byte_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_valid) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (baud_last) state_next = DATA;
            end
            DATA: begin
                if (baud_last && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    byte_done = 1'b1;
                    if (byte_valid) begin
                        state_next = START;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset forces the line idle
    // immediately.
    always_comb begin
        txd = 1'b1;
        unique case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            state <= state_next;
            if (state_next != state || baud_last || state == IDLE) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
            if (load) begin
                shreg   <= byte_data;
                bit_idx <= 3'd0;
            end else if (state == DATA && baud_last) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: latches {header, payload[, checksum]} on send && ready and
// sends it as back-to-back 8N1 bytes, header then payload, MSB byte first.
// Ports: clk, reset (async, active-low), payload, send, ready, busy, txd,
// frame_done. Optional checksum byte: define UART_FRAME_CHECKSUM_EN.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int          HEADER_BYTES  = 2,
    parameter logic [31:0] HEADER        = {16'h0000, LIDAR_HEADER},
    parameter int          PAYLOAD_BYTES = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PAYLOAD_BYTES*8-1:0] payload,
    input  logic                       send,
    output logic                       ready,
    output logic                       busy,
    output logic                       txd,
    output logic                       frame_done
);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CK_BYTES = 1;
`else
    localparam int CK_BYTES = 0;
`endif
    localparam int FRAME_BYTES = HEADER_BYTES + PAYLOAD_BYTES + CK_BYTES;
    localparam int FW          = FRAME_BYTES * 8;
    localparam int LW          = $clog2(FRAME_BYTES);

    logic [FW-1:0] frame_new;
    logic [FW-1:0] frame_q;
    logic [LW-1:0] bytes_left;
    logic          busy_q;
    logic          done_q;
    logic          accept;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_done;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] check_byte;
    assign check_byte = payload_checksum(MAX_PAYLOAD_W'(payload));
    assign frame_new  = {HEADER[HEADER_BYTES*8-1:0], payload, check_byte};
`else
    assign frame_new  = {HEADER[HEADER_BYTES*8-1:0], payload};
`endif

    assign accept = send && !busy_q;

    // The first byte comes straight from the incoming frame so its start
    // bit begins the cycle after accept; later bytes come from frame_q,
    // which always holds the next byte in its top bits.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        if (busy_q) begin
            byte_valid = (bytes_left != '0);
            byte_data  = frame_q[FW-1 -: 8];
        end else begin
            byte_valid = send;
            byte_data  = frame_new[FW-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q    <= '0;
            bytes_left <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q     <= 1'b1;
                frame_q    <= frame_new << 8;
                bytes_left <= LW'(FRAME_BYTES - 1);
            end else if (busy_q && byte_done) begin
                if (bytes_left == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    bytes_left <= bytes_left - LW'(1);
                    frame_q    <= frame_q << 8;
                end
            end
        end
    end

    assign ready      = !busy_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_done  (byte_done),
        .txd        (txd)
    );

endmodule
